// File: rtl/half_adder.sv
// Registered lane-parallel half adder: WIDTH independent lanes, sum = a ^ b, cout = a & b.
// Optional saturating carry-lane counter enabled by defining HALF_ADDER_CARRY_CNT_EN.
module half_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] cout,
`ifdef HALF_ADDER_CARRY_CNT_EN
    output logic [15:0]      carry_count,
`endif
    output logic             out_valid
);

    // Valid semantics: a/b are sampled only on edges where in_valid=1; the result
    // appears one edge later with out_valid pulsed for that single cycle. There is
    // no ready/backpressure, and sum/cout hold their value on edges without in_valid.
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] cout_q, cout_d;
    logic             valid_q, valid_d;

    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d  = a ^ b;
            cout_d = a & b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;

`ifdef HALF_ADDER_CARRY_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  pop;
    logic [16:0] cnt_sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + 7'(a[i] & b[i]);
        end
        // The 17th bit flags overflow so the counter can clamp instead of wrapping.
        cnt_sum = {1'b0, cnt_q} + 17'(pop);
        cnt_d   = cnt_q;
        if (in_valid) begin
            cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_count = cnt_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder (WIDTH=8): directed vectors feed an expected queue drained by a monitor.
// Carry-counter checks are active when HALF_ADDER_CARRY_CNT_EN is defined.
module tb_half_adder;

    localparam int W  = 8;
    localparam int EW = 16 + 2 * W;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic [W-1:0] cout;
    logic         out_valid;
    logic [15:0]  cc_act;

`ifdef HALF_ADDER_CARRY_CNT_EN
    logic [15:0] carry_count;
    assign cc_act = carry_count;
`else
    assign cc_act = 16'h0;
`endif

    half_adder #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .a           (a),
        .b           (b),
        .sum         (sum),
        .cout        (cout),
`ifdef HALF_ADDER_CARRY_CNT_EN
        .carry_count (carry_count),
`endif
        .out_valid   (out_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_exp = '0;
    logic [15:0]   cc_model = '0;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got cc=%h sum=%h cout=%h, expected cc=%h sum=%h cout=%h", name,
                     act[EW-1 -: 16], act[2*W-1 -: W], act[W-1:0],
                     exp[EW-1 -: 16], exp[2*W-1 -: W], exp[W-1:0]);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sat_add(input logic [15:0] cur, input logic [W-1:0] c);
        logic [16:0] s;
        s = {1'b0, cur} + 17'($countones(c));
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // driver: one edge per call; a/b are random when not valid
    task automatic drive(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] es, input logic [W-1:0] ec, input logic v);
        @(posedge clk);
        #1;
        in_valid = v;
        if (v) begin
            a = va;
            b = vb;
`ifdef HALF_ADDER_CARRY_CNT_EN
            cc_model = sat_add(cc_model, ec);
`endif
            exp_q.push_back({cc_model, es, ec});
        end else begin
            a = W'($urandom);
            b = W'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, '0, '0, 1'b0);
    endtask

    // Called #1 after an edge: reset asserts mid-cycle and is held across the next edge.
    task automatic do_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check({tag, "_async_out"}, {cc_act, sum, cout}, '0);
        check_bit({tag, "_async_valid"}, out_valid, 1'b0);
        exp_q.delete();
        cc_model = '0;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    // monitor / scoreboard
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                last_exp = '0;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_out_valid: got out_valid=1, expected no result");
                end else begin
                    e = exp_q.pop_front();
                    check("result", {cc_act, sum, cout}, e);
                    last_exp = e;
                end
            end else begin
                check("hold", {cc_act, sum, cout}, last_exp);
            end
        end
    end

    // stimulus
    initial begin
        int waited;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        #2;
        check("por_out", {cc_act, sum, cout}, '0);
        check_bit("por_valid", out_valid, 1'b0);
        #10;
        rst_n = 1'b1;

        // truth table on all lanes: 00,01,10,11
        drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        drive(8'h00, 8'hFF, 8'hFF, 8'h00, 1'b1);
        drive(8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1);
        drive(8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1);
        // mixed lanes, no inter-lane carry
        drive(8'hF0, 8'h3C, 8'hCC, 8'h30, 1'b1);
        drive(8'hA5, 8'h0F, 8'hAA, 8'h05, 1'b1);
        drive(8'h55, 8'hAA, 8'hFF, 8'h00, 1'b1);
        idle(1);
        drive(8'h81, 8'h81, 8'h00, 8'h81, 1'b1);

        // hold: 1+1 then invalid inputs must not be sampled
        drive(8'h01, 8'h01, 8'h00, 8'h01, 1'b1);
        drive(8'h00, 8'h01, 8'h00, 8'h00, 1'b0);
        idle(2);

        // async reset with nonzero sum and cout
        drive(8'h03, 8'h01, 8'h02, 8'h01, 1'b1);
        idle(1);
        do_reset("rst_idle");
        idle(1);

        // reset mid-stream discards the in-flight transaction
        drive(8'h01, 8'h01, 8'h00, 8'h01, 1'b1);
        do_reset("rst_mid");
        drive(8'h00, 8'h01, 8'h01, 8'h00, 1'b1);
        idle(2);

`ifdef HALF_ADDER_CARRY_CNT_EN
        do_reset("rst_cc");
        for (int i = 0; i < 3; i++) drive(8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1);
        idle(1);
        check("cc_24", {cc_act, 16'h0}, {16'd24, 16'h0});
        for (int i = 3; i < 8191; i++) drive(8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1);
        drive(8'h03, 8'h03, 8'h00, 8'h03, 1'b1);
        idle(1);
        check("cc_preload", {cc_act, 16'h0}, {16'hFFFA, 16'h0});
        drive(8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1);
        drive(8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1);
        idle(1);
        check("cc_sat", {cc_act, 16'h0}, {16'hFFFF, 16'h0});
`endif

        idle(2);
        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
